// File: rtl/scp_containment_fsm.sv
// scp_containment_fsm: escalating containment alarm FSM driven by one-hot green/yellow/red operator inputs
module scp_containment_fsm #(
  parameter int TIMER_W      = 6,
  parameter int LEVELS       = 3,
  parameter int INIT_DWELL   = 35,
  parameter int DWELL        = 20,
  parameter int COOL         = 8,
  parameter int LOCK_RELEASE = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  output logic [2:0]         state,
  output logic [2:0]         level,
  output logic [LEVELS-1:0]  alarm,
  output logic               cheat_out,
  output logic [TIMER_W-1:0] timer
);
  localparam int TMAX = (1 << TIMER_W) - 1;
  if (TIMER_W < 1 || TIMER_W > 30 || LEVELS < 1 || LEVELS > 7 ||
      INIT_DWELL < 1 || INIT_DWELL > TMAX || DWELL < 1 || DWELL > TMAX ||
      COOL < 1 || COOL > TMAX || LOCK_RELEASE < 1 || LOCK_RELEASE > TMAX) begin : g_bad_params
    $error("scp_containment_fsm: parameter out of range");
  end
  typedef enum logic [2:0] {SAFE, ARMED, ALERT, COOLDOWN, LOCKDOWN, CHEAT} state_t;
  localparam logic [2:0]         LMAX   = 3'(LEVELS);
  localparam logic [TIMER_W-1:0] T_INIT = TIMER_W'(INIT_DWELL - 1);
  localparam logic [TIMER_W-1:0] T_DWL  = TIMER_W'(DWELL - 1);
  localparam logic [TIMER_W-1:0] T_COOL = TIMER_W'(COOL - 1);
  localparam logic [TIMER_W-1:0] T_LOCK = TIMER_W'(LOCK_RELEASE - 1);
  state_t             state_q, state_d, esc_state;
  logic [2:0]         level_q, level_d, esc_level;
  logic [TIMER_W-1:0] timer_q, timer_d, tinc;
  logic               cheat_q, cheat_d, one_hot, multi;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SAFE;
      level_q <= '0;
      timer_q <= '0;
      cheat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      timer_q <= timer_d;
      cheat_q <= cheat_d;
    end
  end
  // escalation saturates into LOCKDOWN once the top level is already reached
  always_comb begin
    one_hot   = (3'(green) + 3'(yellow) + 3'(red)) == 3'd1;
    multi     = (3'(green) + 3'(yellow) + 3'(red)) > 3'd1;
    tinc      = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    esc_state = (level_q == LMAX) ? LOCKDOWN : ALERT;
    esc_level = (level_q == LMAX) ? LMAX : level_q + 3'd1;
    state_d   = state_q;
    level_d   = level_q;
    timer_d   = timer_q;
    cheat_d   = cheat_q;
    if (state_q > CHEAT) begin
      state_d = SAFE;
      level_d = '0;
      timer_d = '0;
      cheat_d = 1'b0;
    end else if (multi) begin
      state_d = CHEAT;
      level_d = LMAX;
      timer_d = '0;
      cheat_d = 1'b1;
    end else if (one_hot) begin
      case (state_q)
        SAFE: begin
          state_d = red ? ALERT : (green && timer_q == T_INIT) ? ARMED : SAFE;
          level_d = red ? 3'd1 : 3'd0;
          timer_d = (red || yellow || timer_q == T_INIT) ? '0 : tinc;
        end
        ARMED: begin
          state_d = (red || timer_q == T_DWL) && !yellow ? ALERT : yellow ? SAFE : ARMED;
          level_d = (state_d == ALERT) ? 3'd1 : 3'd0;
          timer_d = (state_d == ARMED) ? tinc : '0;
        end
        ALERT: begin
          state_d = yellow ? COOLDOWN : (red || timer_q == T_DWL) ? esc_state : ALERT;
          level_d = (red || (green && timer_q == T_DWL)) ? esc_level : level_q;
          timer_d = (green && timer_q != T_DWL) ? tinc : '0;
        end
        COOLDOWN: begin
          state_d = red ? esc_state : green ? ALERT :
                    (timer_q == T_COOL && level_q == 3'd1) ? SAFE : COOLDOWN;
          level_d = red ? esc_level : (yellow && timer_q == T_COOL) ? level_q - 3'd1 : level_q;
          timer_d = (yellow && timer_q != T_COOL) ? tinc : '0;
        end
        LOCKDOWN: begin
          state_d = (yellow && timer_q == T_LOCK) ? COOLDOWN : LOCKDOWN;
          level_d = LMAX;
          timer_d = (yellow && timer_q != T_LOCK) ? tinc : '0;
        end
        default: ;
      endcase
    end
  end
  for (genvar i = 0; i < LEVELS; i++) begin : g_alarm
    assign alarm[i] = level_q > 3'(i);
  end
  assign state     = state_q;
  assign level     = level_q;
  assign timer     = timer_q;
  assign cheat_out = cheat_q;
endmodule

// File: tb/tb_scp_containment_fsm.sv
// tb_scp_containment_fsm: randomized scoreboard bench against a rule-level model of the containment FSM
module tb_scp_containment_fsm;
  localparam int TW = 6, L = 3, INIT = 35, DW = 20, CL = 8, LR = 16;
  logic clock = 1'b0, reset = 1'b1, green = 1'b0, yellow = 1'b0, red = 1'b0;
  logic [2:0] state, level;
  logic [L-1:0] alarm;
  logic cheat_out;
  logic [TW-1:0] timer;
  scp_containment_fsm #(.TIMER_W(TW), .LEVELS(L), .INIT_DWELL(INIT), .DWELL(DW),
    .COOL(CL), .LOCK_RELEASE(LR)) dut (.clock(clock), .reset(reset), .green(green),
    .yellow(yellow), .red(red), .state(state), .level(level), .alarm(alarm),
    .cheat_out(cheat_out), .timer(timer));
  always #5 clock = ~clock;
  typedef struct {int st; int lv; int tm; int ch;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int ms = 0, ml = 0, mt = 0, mc = 0;
  function automatic void go(int s, int l);
    ms = s; ml = l; mt = 0;
  endfunction
  function automatic void escalate();
    if (ml == L) go(4, L); else go(2, ml + 1);
  endfunction
  // returns 1 when this held cycle completes the dwell, otherwise advances the count
  function automatic bit count(int lim);
    if (mt == lim - 1) return 1'b1;
    mt = (mt + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : mt + 1;
    return 1'b0;
  endfunction
  function automatic void step(bit rs, bit g, bit y, bit r);
    int n = int'(g) + int'(y) + int'(r);
    if (rs) begin ms = 0; ml = 0; mt = 0; mc = 0; return; end
    if (n == 0) return;
    if (n > 1) begin go(5, L); mc = 1; return; end
    case (ms)
      0: if (r) go(2, 1); else if (g) begin if (count(INIT)) go(1, 0); end else mt = 0;
      1: if (r) go(2, 1); else if (y) go(0, 0); else if (count(DW)) go(2, 1);
      2: if (r) escalate(); else if (y) go(3, ml); else if (count(DW)) escalate();
      3: if (r) escalate(); else if (g) go(2, ml);
         else if (count(CL)) begin if (ml == 1) go(0, 0); else go(3, ml - 1); end
      4: if (y) begin if (count(LR)) go(3, L); end else mt = 0;
      default: ;
    endcase
  endfunction
  task automatic drive(bit rs, bit g, bit y, bit r, int n = 1);
    repeat (n) begin
      @(negedge clock);
      reset = rs; green = g; yellow = y; red = r;
      step(rs, g, y, r);
      q.push_back('{ms, ml, mt, mc});
    end
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", int'(state), e.st);
      chk("level", int'(level), e.lv);
      chk("alarm", int'(alarm), (1 << e.lv) - 1);
      chk("timer", int'(timer), e.tm);
      chk("cheat", int'(cheat_out), e.ch);
    end
  end
  initial begin
    drive(1, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 35);
    drive(0, 1, 0, 0, 20);
    drive(0, 1, 0, 0, 40);
    drive(0, 1, 0, 0, 20);
    drive(0, 0, 1, 0, 16);
    drive(0, 0, 1, 0, 30);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    drive(0, 0, 1, 0, 5); drive(0, 0, 0, 0); drive(0, 0, 1, 0, 14);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1); drive(0, 0, 0, 0); end
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0, 45);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0, 50);
    drive(0, 0, 1, 0, 3);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0, 30);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0, 36);
    repeat (500) begin
      int k = $urandom_range(0, 99);
      if (k < 3) drive(1, 0, 0, 0);
      else if (k < 5) begin
        int p = $urandom_range(3, 7);
        if (p == 4) p = 6;
        drive(0, p[0], p[1], p[2]);
        drive(0, 0, 0, 0, $urandom_range(1, 5));
        drive(1, 0, 0, 0);
      end else if (k < 20) drive(0, 0, 0, 1, $urandom_range(1, 2));
      else if (k < 30) drive(0, 0, 0, 0, $urandom_range(1, 4));
      else if (k < 60) drive(0, 1, 0, 0, $urandom_range(1, 45));
      else drive(0, 0, 1, 0, $urandom_range(1, 40));
    end
    repeat (3) @(posedge clock);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
